// File: rtl/interrupt_controller_if.sv
// Bundles the daisy-chain bus and CPU-side signals of the interrupt controller.
// The controller uses the slave view; the driving environment uses the master view.
interface interrupt_controller_if;
    logic       enable;
    logic       anyInterrupt;
    logic       grantValid;
    logic [7:0] busTrapType;
    logic [3:0] busLevel;
    logic [3:0] cpuMask;
    logic       cpuAck;
    logic       cpuDone;
    logic       chainPI;
    logic       chainHandled;
    logic       irqReq;
    logic [7:0] trapVector;
    logic [3:0] irqLevel;
    logic       spurious;
    logic       busy;
    logic [7:0] serviceCount;

    modport slave (
        input  enable, anyInterrupt, grantValid, busTrapType, busLevel,
               cpuMask, cpuAck, cpuDone,
        output chainPI, chainHandled, irqReq, trapVector, irqLevel,
               spurious, busy, serviceCount
    );

    modport master (
        output enable, anyInterrupt, grantValid, busTrapType, busLevel,
               cpuMask, cpuAck, cpuDone,
        input  chainPI, chainHandled, irqReq, trapVector, irqLevel,
               spurious, busy, serviceCount
    );
endinterface

// File: rtl/interrupt_controller.sv
// CPU-side head of the daisy-chained interrupt bus: polls the chain, filters the
// granted request against the CPU mask, dispatches it and releases the device.
module interrupt_controller #(
    parameter int TIMEOUT        = 16,
    parameter int HANDLED_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    interrupt_controller_if.slave bus
);
    localparam int CNT_MAX = (TIMEOUT > HANDLED_CYCLES) ? TIMEOUT : HANDLED_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, POLL, CHECK, MASKED, DISPATCH, SERVICE, RELEASE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    trap_q, trap_d;
    logic [3:0]    level_q, level_d;
    logic [7:0]    count_q, count_d;
    logic          spurious_q, spurious_d;
    logic          chain_pi_q, chain_pi_d;
    logic          handled_q, handled_d;
    logic          irq_req_q, irq_req_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        trap_d     = trap_q;
        level_d    = level_q;
        count_d    = count_q;
        spurious_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.enable && bus.anyInterrupt) begin
                    state_d = POLL;
                    cnt_d   = '0;
                end
            end
            POLL: begin
                // A grant wins over both a disable and the timeout in the same cycle.
                if (bus.grantValid) begin
                    trap_d  = bus.busTrapType;
                    level_d = bus.busLevel;
                    state_d = CHECK;
                end else if (!bus.enable) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    spurious_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHECK: begin
                state_d = (level_q > bus.cpuMask) ? DISPATCH : MASKED;
            end
            MASKED: begin
                // The level compared is the one being captured, so the dispatched
                // vector always matches the decision that released it.
                if (!bus.grantValid || !bus.enable) begin
                    state_d = IDLE;
                end else begin
                    trap_d  = bus.busTrapType;
                    level_d = bus.busLevel;
                    if (bus.busLevel > bus.cpuMask) state_d = DISPATCH;
                end
            end
            DISPATCH: begin
                if (bus.cpuAck) state_d = bus.cpuDone ? RELEASE : SERVICE;
            end
            SERVICE: begin
                if (bus.cpuDone) state_d = RELEASE;
            end
            RELEASE: begin
                if (cnt_q == CW'(HANDLED_CYCLES - 1)) state_d = IDLE;
                else                                  cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (state_d == RELEASE && state_q != RELEASE) begin
            cnt_d = '0;
            if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end
    end

    // Outputs are registered views of the next state.
    always_comb begin
        chain_pi_d = (state_d == POLL) || (state_d == CHECK) || (state_d == MASKED) ||
                     (state_d == DISPATCH) || (state_d == SERVICE);
        handled_d  = (state_d == RELEASE);
        irq_req_d  = (state_d == DISPATCH);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            trap_q     <= '0;
            level_q    <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
            chain_pi_q <= 1'b0;
            handled_q  <= 1'b0;
            irq_req_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            trap_q     <= trap_d;
            level_q    <= level_d;
            count_q    <= count_d;
            spurious_q <= spurious_d;
            chain_pi_q <= chain_pi_d;
            handled_q  <= handled_d;
            irq_req_q  <= irq_req_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.chainPI      = chain_pi_q;
    assign bus.chainHandled = handled_q;
    assign bus.irqReq       = irq_req_q;
    assign bus.trapVector   = trap_q;
    assign bus.irqLevel     = level_q;
    assign bus.spurious     = spurious_q;
    assign bus.busy         = busy_q;
    assign bus.serviceCount = count_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed testbench for interrupt_controller: each task drives one scenario and
// checks hand-computed expectations inline.
module tb_interrupt_controller;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    interrupt_controller_if bus ();

    interrupt_controller #(.TIMEOUT(16), .HANDLED_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.enable       = 1'b0;
        bus.anyInterrupt = 1'b0;
        bus.grantValid   = 1'b0;
        bus.busTrapType  = 8'h00;
        bus.busLevel     = 4'h0;
        bus.cpuMask      = 4'h0;
        bus.cpuAck       = 1'b0;
        bus.cpuDone      = 1'b0;
    endtask

    // Stimulus only: one complete request/grant/ack/done/release sequence.
    task automatic run_service(input logic [7:0] trap, input logic [3:0] lvl);
        bus.enable = 1'b1; bus.anyInterrupt = 1'b1;
        bus.busTrapType = trap; bus.busLevel = lvl; bus.cpuMask = 4'h0;
        tick();
        tick();
        bus.grantValid = 1'b1;
        tick();
        tick();
        bus.cpuAck = 1'b1;
        tick();
        bus.cpuAck = 1'b0; bus.cpuDone = 1'b1;
        tick();
        bus.cpuDone = 1'b0; bus.anyInterrupt = 1'b0; bus.grantValid = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (3) tick();
        total++; if (bus.chainPI !== 1'b0) begin bad++; $display("FAIL reset_chainPI got=%0h want=0", bus.chainPI); end
        total++; if (bus.chainHandled !== 1'b0) begin bad++; $display("FAIL reset_chainHandled got=%0h want=0", bus.chainHandled); end
        total++; if (bus.irqReq !== 1'b0) begin bad++; $display("FAIL reset_irqReq got=%0h want=0", bus.irqReq); end
        total++; if ({bus.trapVector, bus.irqLevel} !== 12'h000) begin bad++; $display("FAIL reset_vector got=%0h want=0", {bus.trapVector, bus.irqLevel}); end
        total++; if ({bus.spurious, bus.busy} !== 2'b00) begin bad++; $display("FAIL reset_spur_busy got=%0b want=00", {bus.spurious, bus.busy}); end
        total++; if (bus.serviceCount !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.serviceCount); end
        reset = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_single();
        bus.enable = 1'b1; bus.anyInterrupt = 1'b1;
        bus.busTrapType = 8'h20; bus.busLevel = 4'd3; bus.cpuMask = 4'd0;
        tick();
        total++; if ({bus.chainPI, bus.busy} !== 2'b11) begin bad++; $display("FAIL single_poll got=%0b want=11", {bus.chainPI, bus.busy}); end
        tick();
        bus.grantValid = 1'b1;
        tick();
        total++; if (bus.irqReq !== 1'b0) begin bad++; $display("FAIL single_check_irq got=%0h want=0", bus.irqReq); end
        tick();
        total++; if (bus.irqReq !== 1'b1) begin bad++; $display("FAIL single_irq got=%0h want=1", bus.irqReq); end
        total++; if (bus.trapVector !== 8'h20) begin bad++; $display("FAIL single_trap got=%0h want=20", bus.trapVector); end
        total++; if (bus.irqLevel !== 4'd3) begin bad++; $display("FAIL single_level got=%0h want=3", bus.irqLevel); end
        bus.cpuAck = 1'b1;
        tick();
        total++; if ({bus.irqReq, bus.chainPI} !== 2'b01) begin bad++; $display("FAIL single_service got=%0b want=01", {bus.irqReq, bus.chainPI}); end
        bus.cpuAck = 1'b0; bus.cpuDone = 1'b1;
        tick();
        total++; if ({bus.chainHandled, bus.chainPI} !== 2'b10) begin bad++; $display("FAIL single_release got=%0b want=10", {bus.chainHandled, bus.chainPI}); end
        total++; if (bus.serviceCount !== 8'd1) begin bad++; $display("FAIL single_count got=%0d want=1", bus.serviceCount); end
        bus.cpuDone = 1'b0; bus.anyInterrupt = 1'b0; bus.grantValid = 1'b0;
        tick();
        total++; if (bus.chainHandled !== 1'b1) begin bad++; $display("FAIL single_handled2 got=%0h want=1", bus.chainHandled); end
        tick();
        total++; if ({bus.chainHandled, bus.busy} !== 2'b00) begin bad++; $display("FAIL single_idle got=%0b want=00", {bus.chainHandled, bus.busy}); end
        $display("test_single done trap=%0h level=%0d", bus.trapVector, bus.irqLevel);
    endtask

    task automatic test_spurious();
        int seen_at;
        seen_at = 0;
        bus.enable = 1'b1; bus.anyInterrupt = 1'b1; bus.grantValid = 1'b0;
        tick();
        total++; if (bus.chainPI !== 1'b1) begin bad++; $display("FAIL spur_poll got=%0h want=1", bus.chainPI); end
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.spurious === 1'b1) begin
                seen_at = i;
                break;
            end
        end
        total++; if (seen_at != 16) begin bad++; $display("FAIL spur_delay got=%0d want=16", seen_at); end
        total++; if ({bus.chainPI, bus.busy} !== 2'b00) begin bad++; $display("FAIL spur_idle got=%0b want=00", {bus.chainPI, bus.busy}); end
        bus.anyInterrupt = 1'b0;
        tick();
        total++; if (bus.spurious !== 1'b0) begin bad++; $display("FAIL spur_width got=%0h want=0", bus.spurious); end
        total++; if (bus.serviceCount !== 8'd1) begin bad++; $display("FAIL spur_count got=%0d want=1", bus.serviceCount); end
        $display("test_spurious done after %0d cycles", seen_at);
    endtask

    task automatic test_masking();
        bus.enable = 1'b1; bus.anyInterrupt = 1'b1;
        bus.busTrapType = 8'h41; bus.busLevel = 4'd2; bus.cpuMask = 4'd5;
        tick();
        tick();
        bus.grantValid = 1'b1;
        tick();
        tick();
        tick();
        total++; if ({bus.irqReq, bus.chainPI, bus.busy} !== 3'b011) begin bad++; $display("FAIL mask_hold got=%0b want=011", {bus.irqReq, bus.chainPI, bus.busy}); end
        bus.cpuMask = 4'd1;
        tick();
        total++; if (bus.irqReq !== 1'b1) begin bad++; $display("FAIL mask_dispatch got=%0h want=1", bus.irqReq); end
        total++; if ({bus.trapVector, bus.irqLevel} !== 12'h412) begin bad++; $display("FAIL mask_vector got=%0h want=412", {bus.trapVector, bus.irqLevel}); end
        bus.cpuAck = 1'b1;
        tick();
        bus.cpuAck = 1'b0; bus.cpuDone = 1'b1;
        tick();
        bus.cpuDone = 1'b0; bus.anyInterrupt = 1'b0; bus.grantValid = 1'b0;
        tick();
        tick();
        total++; if (bus.serviceCount !== 8'd2) begin bad++; $display("FAIL mask_count got=%0d want=2", bus.serviceCount); end
        $display("test_masking done level=%0d", bus.irqLevel);
    endtask

    task automatic test_ack_done_together();
        bus.enable = 1'b1; bus.anyInterrupt = 1'b1;
        bus.busTrapType = 8'h33; bus.busLevel = 4'd7; bus.cpuMask = 4'd0;
        tick();
        tick();
        bus.grantValid = 1'b1;
        tick();
        tick();
        total++; if (bus.irqReq !== 1'b1) begin bad++; $display("FAIL both_irq got=%0h want=1", bus.irqReq); end
        bus.cpuAck = 1'b1; bus.cpuDone = 1'b1;
        tick();
        total++; if ({bus.chainHandled, bus.irqReq, bus.chainPI} !== 3'b100) begin bad++; $display("FAIL both_release got=%0b want=100", {bus.chainHandled, bus.irqReq, bus.chainPI}); end
        clear_inputs();
        tick();
        total++; if (bus.chainHandled !== 1'b1) begin bad++; $display("FAIL both_handled2 got=%0h want=1", bus.chainHandled); end
        tick();
        total++; if ({bus.chainHandled, bus.busy} !== 2'b00) begin bad++; $display("FAIL both_idle got=%0b want=00", {bus.chainHandled, bus.busy}); end
        total++; if (bus.serviceCount !== 8'd3) begin bad++; $display("FAIL both_count got=%0d want=3", bus.serviceCount); end
        $display("test_ack_done_together done");
    endtask

    task automatic test_reset_in_service();
        bus.enable = 1'b1; bus.anyInterrupt = 1'b1;
        bus.busTrapType = 8'h55; bus.busLevel = 4'd4; bus.cpuMask = 4'd0;
        tick();
        tick();
        bus.grantValid = 1'b1;
        tick();
        tick();
        bus.cpuAck = 1'b1;
        tick();
        bus.cpuAck = 1'b0;
        total++; if ({bus.busy, bus.chainPI} !== 2'b11) begin bad++; $display("FAIL rsvc_in_service got=%0b want=11", {bus.busy, bus.chainPI}); end
        #2 reset = 1'b0;
        #1;
        total++; if ({bus.irqReq, bus.chainPI, bus.chainHandled, bus.busy} !== 4'b0000) begin bad++; $display("FAIL rsvc_async got=%0b want=0000", {bus.irqReq, bus.chainPI, bus.chainHandled, bus.busy}); end
        total++; if ({bus.serviceCount, bus.trapVector} !== 16'h0000) begin bad++; $display("FAIL rsvc_state got=%0h want=0", {bus.serviceCount, bus.trapVector}); end
        clear_inputs();
        tick();
        reset = 1'b1;
        tick();
        run_service(8'h66, 4'd1);
        total++; if ({bus.serviceCount, bus.trapVector} !== 16'h0166) begin bad++; $display("FAIL rsvc_fresh got=%0h want=0166", {bus.serviceCount, bus.trapVector}); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rsvc_idle got=%0h want=0", bus.busy); end
        $display("test_reset_in_service done count=%0d", bus.serviceCount);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 253; i++) run_service(8'(i), 4'd9);
        total++; if (bus.serviceCount !== 8'd254) begin bad++; $display("FAIL b2b_254 got=%0d want=254", bus.serviceCount); end
        run_service(8'hA0, 4'd9);
        total++; if (bus.serviceCount !== 8'd255) begin bad++; $display("FAIL b2b_255 got=%0d want=255", bus.serviceCount); end
        run_service(8'hA1, 4'd9);
        run_service(8'hA2, 4'd9);
        total++; if (bus.serviceCount !== 8'd255) begin bad++; $display("FAIL b2b_sat got=%0d want=255", bus.serviceCount); end
        total++; if (bus.trapVector !== 8'hA2) begin bad++; $display("FAIL b2b_trap got=%0h want=a2", bus.trapVector); end
        $display("test_back_to_back done count=%0d", bus.serviceCount);
    endtask

    task automatic test_enable_drop();
        int pulses;
        pulses = 0;
        bus.enable = 1'b1; bus.anyInterrupt = 1'b1; bus.grantValid = 1'b0;
        tick();
        total++; if (bus.chainPI !== 1'b1) begin bad++; $display("FAIL endrop_poll got=%0h want=1", bus.chainPI); end
        tick();
        bus.enable = 1'b0;
        tick();
        total++; if ({bus.chainPI, bus.busy} !== 2'b00) begin bad++; $display("FAIL endrop_idle got=%0b want=00", {bus.chainPI, bus.busy}); end
        if (bus.spurious === 1'b1) pulses++;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.spurious === 1'b1) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL endrop_spurious got=%0d want=0", pulses); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL endrop_stay got=%0h want=0", bus.busy); end
        clear_inputs();
        $display("test_enable_drop done");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_spurious();
        test_masking();
        test_ack_done_together();
        test_reset_in_service();
        test_back_to_back();
        test_enable_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
